irq_stim_gen: RTL and testbench



---
 rtl/irq_stim_pkg.sv | 28 ++
 rtl/irq_stim_chan.sv | 163 ++++++++++++++++
 rtl/irq_stim_gen.sv | 81 ++++++++
 tb/tb_irq_stim_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/irq_stim_pkg.sv
// Shared types and reset defaults for the interrupt stimulus generator.
package irq_stim_pkg;

   // Per-channel pulse FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } irq_state_e;

   // Default parameter values of irq_stim_gen.
   localparam int unsigned IRQ_DEF_NUM_CH    = 4;
   localparam int unsigned IRQ_DEF_ADDR_W    = 32;
   localparam int unsigned IRQ_DEF_LEN_W     = 8;
   localparam int unsigned IRQ_DEF_CNT_W     = 4;
   localparam logic [31:0] IRQ_DEF_TRIG_ADDR = 32'h0000_3018;
   localparam int unsigned IRQ_DEF_PULSE_LEN = 6;
   localparam int unsigned IRQ_DEF_MAX_FIRES = 1;

   // One channel's configuration at the default field widths.
   typedef struct packed {
      logic                      en;
      logic [IRQ_DEF_ADDR_W-1:0] trig_addr;
      logic [IRQ_DEF_LEN_W-1:0]  pulse_len;
      logic [IRQ_DEF_CNT_W-1:0]  max_fires;
   } irq_cfg_t;

endpackage

// File: rtl/irq_stim_chan.sv
// One interrupt stimulus channel: config registers, pulse FSM, fire counter.
// Optional macro IRQ_STIM_ACK_EN adds an acknowledge input that ends a pulse
// early and lets pulse_len=0 mean "hold until acknowledged".
module irq_stim_chan
   import irq_stim_pkg::*;
#(
   parameter int unsigned       ADDR_W   = IRQ_DEF_ADDR_W,
   parameter int unsigned       LEN_W    = IRQ_DEF_LEN_W,
   parameter int unsigned       CNT_W    = IRQ_DEF_CNT_W,
   parameter bit                RST_EN   = 1'b0,
   parameter logic [ADDR_W-1:0] RST_TRIG = ADDR_W'(IRQ_DEF_TRIG_ADDR),
   parameter logic [LEN_W-1:0]  RST_LEN  = LEN_W'(IRQ_DEF_PULSE_LEN),
   parameter logic [CNT_W-1:0]  RST_MAX  = CNT_W'(IRQ_DEF_MAX_FIRES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_trig_addr,
   input  logic [LEN_W-1:0]  wr_pulse_len,
   input  logic [CNT_W-1:0]  wr_max_fires,
`ifdef IRQ_STIM_ACK_EN
   input  logic              ack,
`endif
   output logic              irq_next,
   output logic              irq,
   output logic              pending
);

   irq_state_e        state_q, state_d;
   logic              en_q, en_d;
   logic [ADDR_W-1:0] trig_q, trig_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  max_q, max_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  fires_q, fires_d;
   logic              pending_q, pending_d;
   logic              irq_q, irq_d;

   logic              exhausted;
   logic              match;
   logic              refire;
   logic              pulse_end;
   logic [LEN_W-1:0]  cnt_load;
   logic [CNT_W-1:0]  fires_inc;

   // Trigger qualification and the values loaded when a pulse starts.
   always_comb begin
      exhausted = (max_q != '0) && (fires_q == max_q);
      match     = en_q && (addr == trig_q) && !exhausted;
      // A trigger arriving during GAP is folded into the GAP decision.
      refire    = (pending_q || match) && !exhausted;
      cnt_load  = (len_q == '0) ? '0 : len_q - LEN_W'(1);
      // Unlimited channels stop counting at all-ones rather than wrapping.
      fires_inc = (fires_q == '1) ? fires_q : fires_q + CNT_W'(1);
`ifdef IRQ_STIM_ACK_EN
      // pulse_len=0 disables the count timeout; only ack ends the pulse.
      pulse_end = ack || ((cnt_q == '0) && (len_q != '0));
`else
      pulse_end = (cnt_q == '0);
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic; a config write always parks the channel in IDLE.
   always_comb begin
      state_d = state_q;
      if (wr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (match)     state_d = ACTIVE;
            ACTIVE:  if (pulse_end) state_d = GAP;
            GAP:     state_d = refire ? ACTIVE : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs and datapath next values (config, counters, pending, irq).
   always_comb begin
      en_d      = en_q;
      trig_d    = trig_q;
      len_d     = len_q;
      max_d     = max_q;
      cnt_d     = cnt_q;
      fires_d   = fires_q;
      pending_d = pending_q;
      irq_d     = irq_q;
      if (wr) begin
         en_d      = wr_en;
         trig_d    = wr_trig_addr;
         len_d     = wr_pulse_len;
         max_d     = wr_max_fires;
         cnt_d     = '0;
         fires_d   = '0;
         pending_d = 1'b0;
         irq_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (match) begin
                  irq_d   = 1'b1;
                  cnt_d   = cnt_load;
                  fires_d = fires_inc;
               end
            end
            ACTIVE: begin
               // One slot only: a match with pending already set is dropped.
               if (match) pending_d = 1'b1;
               if (pulse_end)          irq_d = 1'b0;
               else if (cnt_q != '0)   cnt_d = cnt_q - LEN_W'(1);
            end
            GAP: begin
               pending_d = 1'b0;
               if (refire) begin
                  irq_d   = 1'b1;
                  cnt_d   = cnt_load;
                  fires_d = fires_inc;
               end
            end
            default: begin
               irq_d     = 1'b0;
               pending_d = 1'b0;
            end
         endcase
      end
   end

   // Channel registers; reset restores the default configuration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q      <= RST_EN;
         trig_q    <= RST_TRIG;
         len_q     <= RST_LEN;
         max_q     <= RST_MAX;
         cnt_q     <= '0;
         fires_q   <= '0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         en_q      <= en_d;
         trig_q    <= trig_d;
         len_q     <= len_d;
         max_q     <= max_d;
         cnt_q     <= cnt_d;
         fires_q   <= fires_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign irq_next = irq_d;
   assign irq      = irq_q;
   assign pending  = pending_q;

endmodule

// File: rtl/irq_stim_gen.sv
// Multi-channel interrupt stimulus generator: watches the CPU PC bus and
// pulses a channel's interrupt line when the PC hits its trigger address.
// Optional macro IRQ_STIM_ACK_EN adds the irq_ack input (early pulse end and
// hold-until-ack for pulse_len=0).
module irq_stim_gen
   import irq_stim_pkg::*;
#(
   parameter int unsigned       NUM_CH        = IRQ_DEF_NUM_CH,
   parameter int unsigned       ADDR_W        = IRQ_DEF_ADDR_W,
   parameter int unsigned       LEN_W         = IRQ_DEF_LEN_W,
   parameter int unsigned       CNT_W         = IRQ_DEF_CNT_W,
   parameter logic [ADDR_W-1:0] DEF_TRIG_ADDR = ADDR_W'(IRQ_DEF_TRIG_ADDR),
   parameter int unsigned       DEF_PULSE_LEN = IRQ_DEF_PULSE_LEN,
   parameter int unsigned       DEF_MAX_FIRES = IRQ_DEF_MAX_FIRES,
   localparam int unsigned      SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic              cfg_en,
   input  logic [ADDR_W-1:0] cfg_trig_addr,
   input  logic [LEN_W-1:0]  cfg_pulse_len,
   input  logic [CNT_W-1:0]  cfg_max_fires,
`ifdef IRQ_STIM_ACK_EN
   input  logic [NUM_CH-1:0] irq_ack,
`endif
   output logic [NUM_CH-1:0] irq_out,
   output logic              irq_any,
   output logic [NUM_CH-1:0] pending
);

   logic [NUM_CH-1:0] irq_next;
   logic              irq_any_q, irq_any_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Selects that decode to no channel simply write nothing.
      logic wr;
      assign wr = cfg_we && (cfg_sel == SEL_W'(i));

      irq_stim_chan #(
         .ADDR_W   (ADDR_W),
         .LEN_W    (LEN_W),
         .CNT_W    (CNT_W),
         .RST_EN   (i == 0),
         .RST_TRIG (DEF_TRIG_ADDR),
         .RST_LEN  (LEN_W'(DEF_PULSE_LEN)),
         .RST_MAX  (CNT_W'(DEF_MAX_FIRES))
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .addr         (addr),
         .wr           (wr),
         .wr_en        (cfg_en),
         .wr_trig_addr (cfg_trig_addr),
         .wr_pulse_len (cfg_pulse_len),
         .wr_max_fires (cfg_max_fires),
`ifdef IRQ_STIM_ACK_EN
         .ack          (irq_ack[i]),
`endif
         .irq_next     (irq_next[i]),
         .irq          (irq_out[i]),
         .pending      (pending[i])
      );
   end

   // Summary line built from next-state values so it lines up with irq_out.
   always_comb begin
      irq_any_d = |irq_next;
   end

   // Summary line register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_any_q <= 1'b0;
      else       irq_any_q <= irq_any_d;
   end

   assign irq_any = irq_any_q;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed bench for irq_stim_gen. Builds with or without IRQ_STIM_ACK_EN.
module tb_irq_stim_gen;
   import irq_stim_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic        cfg_en;
   logic [31:0] cfg_trig_addr;
   logic [7:0]  cfg_pulse_len;
   logic [3:0]  cfg_max_fires;
`ifdef IRQ_STIM_ACK_EN
   logic [3:0]  irq_ack;
`endif
   logic [3:0]  irq_out;
   logic        irq_any;
   logic [3:0]  pending;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cap_irq, cap_any, cap_pend;
   logic [3:0]  cap_vec0;

   irq_stim_gen dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .cfg_we        (cfg_we),
      .cfg_sel       (cfg_sel),
      .cfg_en        (cfg_en),
      .cfg_trig_addr (cfg_trig_addr),
      .cfg_pulse_len (cfg_pulse_len),
      .cfg_max_fires (cfg_max_fires),
`ifdef IRQ_STIM_ACK_EN
      .irq_ack       (irq_ack),
`endif
      .irq_out       (irq_out),
      .irq_any       (irq_any),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic irq_cfg_t mk_cfg(input logic en, input logic [31:0] a,
                                       input logic [7:0] l, input logic [3:0] m);
      irq_cfg_t c;
      c.en        = en;
      c.trig_addr = a;
      c.pulse_len = l;
      c.max_fires = m;
      return c;
   endfunction

   // Called right after a negedge; the write lands on the next posedge.
   task automatic cfg_write(input logic [1:0] sel, input irq_cfg_t c);
      cfg_we        = 1'b1;
      cfg_sel       = sel;
      cfg_en        = c.en;
      cfg_trig_addr = c.trig_addr;
      cfg_pulse_len = c.pulse_len;
      cfg_max_fires = c.max_fires;
      @(negedge clk);
      cfg_we        = 1'b0;
   endtask

   // Cycle k drives addr=a when hits[k]; sample k is taken after edge k.
   task automatic run(input logic [31:0] a, input logic [31:0] hits,
                      input int n, input logic [1:0] ch);
      cap_irq  = '0;
      cap_any  = '0;
      cap_pend = '0;
      for (int k = 0; k < n; k++) begin
         addr = hits[k[4:0]] ? a : 32'h0;
         @(negedge clk);
         cap_irq[k[4:0]]  = irq_out[ch];
         cap_any[k[4:0]]  = irq_any;
         cap_pend[k[4:0]] = pending[ch];
         if (k == 0) cap_vec0 = irq_out;
      end
      addr = 32'h0;
   endtask

   initial begin
      reset = 1'b1; addr = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0;
      cfg_trig_addr = '0; cfg_pulse_len = '0; cfg_max_fires = '0;
`ifdef IRQ_STIM_ACK_EN
      irq_ack = '0;
`endif
      repeat (2) @(negedge clk);
      check_eq("rst_irq_out", 32'(irq_out), 32'h0);
      check_eq("rst_irq_any", 32'(irq_any), 32'h0);
      check_eq("rst_pending", 32'(pending), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Defaults: ch0 fires 6 cycles once, then is exhausted.
      run(32'h3018, 32'h1, 10, 2'd0);
      check_eq("def_pulse", cap_irq, 32'h3F);
      check_eq("def_any", cap_any, 32'h3F);
      check_eq("def_pend", cap_pend, 32'h0);
      check_eq("def_only_ch0", 32'(cap_vec0), 32'h1);
      run(32'h3018, 32'h1, 8, 2'd0);
      check_eq("def_max_fires", cap_irq, 32'h0);

      // Pending: hits at cycles 0 and 2 give 4 high, 1 low, 4 high.
      cfg_write(2'd1, mk_cfg(1'b1, 32'h3000, 8'd4, 4'd0));
      run(32'h3000, 32'b101, 12, 2'd1);
      check_eq("pend_irq", cap_irq, 32'h1EF);
      check_eq("pend_any", cap_any, 32'h1EF);
      check_eq("pend_flag", cap_pend, 32'h1C);

      // Drop: three extra hits during ACTIVE still give one extra pulse.
      run(32'h3000, 32'b1111, 12, 2'd1);
      check_eq("drop_irq", cap_irq, 32'h1EF);
      check_eq("drop_pend", cap_pend, 32'h1E);

      // Reconfig: other-channel write leaves ch0 running; ch0 write clears it.
      cfg_write(2'd0, mk_cfg(1'b1, 32'h3018, 8'd6, 4'd0));
      addr = 32'h3018;
      @(negedge clk);
      addr = 32'h0;
      check_eq("rcfg_fire", 32'(irq_out[0]), 32'h1);
      cfg_write(2'd3, mk_cfg(1'b0, 32'h4000, 8'd1, 4'd0));
      check_eq("rcfg_other_wr", 32'(irq_out[0]), 32'h1);
      cfg_write(2'd0, mk_cfg(1'b1, 32'h3018, 8'd2, 4'd1));
      check_eq("rcfg_clear_irq", 32'(irq_out[0]), 32'h0);
      check_eq("rcfg_clear_any", 32'(irq_any), 32'h0);
      run(32'h3018, 32'h1, 6, 2'd0);
      check_eq("rcfg_len2", cap_irq, 32'h3);
      run(32'h3018, 32'h1, 6, 2'd0);
      check_eq("rcfg_max1", cap_irq, 32'h0);
      addr = 32'h3018;
      cfg_write(2'd0, mk_cfg(1'b1, 32'h3018, 8'd3, 4'd0));
      addr = 32'h0;
      check_eq("rcfg_wr_match_ignored", 32'(irq_out[0]), 32'h0);

      // Asynchronous reset in the middle of a pulse.
      run(32'h3018, 32'h1, 2, 2'd0);
      check_eq("arst_pre", cap_irq, 32'h3);
      #2 reset = 1'b1;
      #1;
      check_eq("arst_irq_out", 32'(irq_out), 32'h0);
      check_eq("arst_irq_any", 32'(irq_any), 32'h0);
      #1 reset = 1'b0;
      @(negedge clk);
      run(32'h3018, 32'h1, 10, 2'd0);
      check_eq("arst_refire", cap_irq, 32'h3F);
      run(32'h3000, 32'h1, 4, 2'd1);
      check_eq("arst_ch1_disabled", cap_irq, 32'h0);

`ifdef IRQ_STIM_ACK_EN
      // Hold-until-ack: idle ack ignored, pulse falls on the ack edge.
      cfg_write(2'd2, mk_cfg(1'b1, 32'h3100, 8'd0, 4'd0));
      irq_ack = 4'b0100;
      @(negedge clk);
      irq_ack = 4'b0000;
      check_eq("ack_idle", 32'(irq_out[2]), 32'h0);
      cap_irq = '0;
      for (int k = 0; k < 13; k++) begin
         addr    = (k == 0) ? 32'h3100 : 32'h0;
         irq_ack = (k == 10) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         cap_irq[k[4:0]] = irq_out[2];
      end
      addr    = 32'h0;
      irq_ack = 4'b0000;
      check_eq("ack_hold", cap_irq, 32'h3FF);
`else
      // Without acknowledge support, pulse_len=0 is a one-cycle pulse.
      cfg_write(2'd2, mk_cfg(1'b1, 32'h3100, 8'd0, 4'd0));
      run(32'h3100, 32'h1, 4, 2'd2);
      check_eq("len0_as_1", cap_irq, 32'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
